cdb_wb_arbiter: RTL and testbench

//  Write-back end of the FU completion interface. Accepts completions from
//  NUM_SRC execution sources and queues them in one FIFO per source.

---
 rtl/cdb_wb_if.sv | 27 ++
 rtl/cdb_wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_cdb_wb_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cdb_wb_if.sv
// Completion-side and CDB-side signal bundle of the write-back arbiter.
interface cdb_wb_if #(
   parameter int NUM_SRC   = 3,
   parameter int PRF_IDX_W = 6,
   parameter int ROB_IDX_W = 5
);
   logic [NUM_SRC-1:0]           src_vld_i;
   logic [NUM_SRC*PRF_IDX_W-1:0] src_tag_i;
   logic [NUM_SRC*64-1:0]        src_value_i;
   logic [NUM_SRC*ROB_IDX_W-1:0] src_rob_i;
   logic [NUM_SRC-1:0]           src_rdy_o;
   logic                         cdb_vld_o;
   logic [PRF_IDX_W-1:0]         cdb_tag_o;
   logic [63:0]                  cdb_value_o;
   logic                         rob_done_o;
   logic [ROB_IDX_W-1:0]         rob_idx_o;

   modport master (
      output src_vld_i, src_tag_i, src_value_i, src_rob_i,
      input  src_rdy_o, cdb_vld_o, cdb_tag_o, cdb_value_o, rob_done_o, rob_idx_o
   );

   modport slave (
      input  src_vld_i, src_tag_i, src_value_i, src_rob_i,
      output src_rdy_o, cdb_vld_o, cdb_tag_o, cdb_value_o, rob_done_o, rob_idx_o
   );
endinterface

// File: rtl/cdb_wb_arbiter.sv
// Write-back arbiter: one small FIFO per completion source, round-robin pick of
// a FIFO head each cycle, registered drive of the CDB / PRF write / ROB done.
module cdb_wb_arbiter #(
   parameter int NUM_SRC   = 3,
   parameter int Q_DEPTH   = 2,
   parameter int PRF_IDX_W = 6,
   parameter int ROB_IDX_W = 5,
   parameter int ZERO_TAG  = 0
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     flush_i,
   cdb_wb_if.slave  bus
);
   localparam int PTR_W = $clog2(Q_DEPTH);
   localparam int CNT_W = $clog2(Q_DEPTH + 1);
   localparam int RR_W  = $clog2(NUM_SRC);
   localparam logic [PRF_IDX_W-1:0] ZTAG = PRF_IDX_W'(ZERO_TAG);

   typedef struct packed {
      logic [PRF_IDX_W-1:0] tag;
      logic [ROB_IDX_W-1:0] rob;
      logic [63:0]          value;
   } entry_t;

   typedef struct packed {
      logic                 vld;
      logic [PRF_IDX_W-1:0] tag;
      logic [63:0]          value;
      logic                 done;
      logic [ROB_IDX_W-1:0] idx;
   } out_t;

   localparam out_t OUT_IDLE = '{vld: 1'b0, tag: ZTAG, value: '0, done: 1'b0, idx: '0};

   entry_t           mem_q   [NUM_SRC][Q_DEPTH];
   logic [PTR_W-1:0] head_q  [NUM_SRC];
   logic [PTR_W-1:0] head_d  [NUM_SRC];
   logic [PTR_W-1:0] tail_q  [NUM_SRC];
   logic [PTR_W-1:0] tail_d  [NUM_SRC];
   logic [CNT_W-1:0] count_q [NUM_SRC];
   logic [CNT_W-1:0] count_d [NUM_SRC];
   logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
   out_t             out_q, out_d;

   entry_t           in_ent [NUM_SRC];
   entry_t           head_ent;
   logic [NUM_SRC-1:0] rdy, push, pop;
   logic             grant_vld;
   logic [RR_W-1:0]  grant_idx, cand;

   // Ready depends on occupancy only, so a full FIFO popping this cycle stays not-ready.
   always_comb begin
      for (int k = 0; k < NUM_SRC; k++) begin
         in_ent[k].tag   = bus.src_tag_i[k*PRF_IDX_W +: PRF_IDX_W];
         in_ent[k].rob   = bus.src_rob_i[k*ROB_IDX_W +: ROB_IDX_W];
         in_ent[k].value = bus.src_value_i[k*64 +: 64];
         rdy[k]  = count_q[k] < CNT_W'(Q_DEPTH);
         push[k] = bus.src_vld_i[k] && rdy[k] && !flush_i;
      end
   end

   // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         cand = RR_W'((int'(rr_ptr_q) + i) % NUM_SRC);
         if (!grant_vld && count_q[cand] != '0) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign head_ent = mem_q[grant_idx][head_q[grant_idx]];

   always_comb begin
      for (int k = 0; k < NUM_SRC; k++) begin
         pop[k]     = grant_vld && (grant_idx == RR_W'(k));
         head_d[k]  = pop[k]  ? head_q[k] + 1'b1 : head_q[k];
         tail_d[k]  = push[k] ? tail_q[k] + 1'b1 : tail_q[k];
         count_d[k] = count_q[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
      end
      rr_ptr_d = rr_ptr_q;
      if (grant_vld) begin
         rr_ptr_d = (grant_idx == RR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
      end

      // A no-destination entry still completes in the ROB but never broadcasts.
      out_d = OUT_IDLE;
      if (grant_vld) begin
         out_d.done = 1'b1;
         out_d.idx  = head_ent.rob;
         if (head_ent.tag != ZTAG) begin
            out_d.vld   = 1'b1;
            out_d.tag   = head_ent.tag;
            out_d.value = head_ent.value;
         end
      end

      if (flush_i) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            head_d[k]  = '0;
            tail_d[k]  = '0;
            count_d[k] = '0;
         end
         rr_ptr_d = '0;
         out_d    = OUT_IDLE;
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            head_q[k]  <= '0;
            tail_q[k]  <= '0;
            count_q[k] <= '0;
         end
         rr_ptr_q <= '0;
         out_q    <= OUT_IDLE;
      end else begin
         for (int k = 0; k < NUM_SRC; k++) begin
            head_q[k]  <= head_d[k];
            tail_q[k]  <= tail_d[k];
            count_q[k] <= count_d[k];
         end
         rr_ptr_q <= rr_ptr_d;
         out_q    <= out_d;
      end
   end

   // NOTE: FIFO storage has no reset; an entry is only read once count says it was written.
   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_SRC; k++) begin
         if (push[k]) mem_q[k][tail_q[k]] <= in_ent[k];
      end
   end

   assign bus.src_rdy_o   = rdy;
   assign bus.cdb_vld_o   = out_q.vld;
   assign bus.cdb_tag_o   = out_q.tag;
   assign bus.cdb_value_o = out_q.value;
   assign bus.rob_done_o  = out_q.done;
   assign bus.rob_idx_o   = out_q.idx;
endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Directed bench for cdb_wb_arbiter: latency, rotation, backpressure, ZERO_TAG, flush, async reset.
module tb_cdb_wb_arbiter;
   localparam int NUM_SRC   = 3;
   localparam int PRF_IDX_W = 6;
   localparam int ROB_IDX_W = 5;
   localparam logic [63:0] VAL_BASE = 64'hC0DE_0000_0000_0000;

   logic clk     = 1'b0;
   logic rst     = 1'b0;
   logic flush_i = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   // Per-edge stimulus/expectation tables for the burst scenarios (index = edge number).
   int   pres    [16][NUM_SRC];
   int   exp_k   [16];
   int   exp_j   [16];
   int   rdy_exp [16];
   logic fl      [16];

   cdb_wb_if #(.NUM_SRC(NUM_SRC), .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W)) bus ();

   cdb_wb_arbiter #(
      .NUM_SRC(NUM_SRC), .Q_DEPTH(2), .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W), .ZERO_TAG(0)
   ) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .bus(bus)
   );

   always #5 clk = ~clk;

   wire [76:0] obs = {bus.cdb_vld_o, bus.cdb_tag_o, bus.cdb_value_o, bus.rob_done_o, bus.rob_idx_o};

   function automatic logic [63:0] ent_value(input int k, input int j);
      return VAL_BASE | (64'(k) << 8) | 64'(j);
   endfunction

   function automatic logic [76:0] exp_vec(input int k, input int j);
      if (k < 0) return '0;
      return {1'b1, 6'(10 + k), ent_value(k, j), 1'b1, 5'(k * 8 + j)};
   endfunction

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      n_checks++;
      assert (got === want) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, got, want);
      end
   endtask

   task automatic drive_raw(input int k, input logic [5:0] tag, input logic [63:0] value,
                            input logic [4:0] rob);
      bus.src_vld_i[k]                  = 1'b1;
      bus.src_tag_i[k*PRF_IDX_W +: PRF_IDX_W] = tag;
      bus.src_value_i[k*64 +: 64]       = value;
      bus.src_rob_i[k*ROB_IDX_W +: ROB_IDX_W] = rob;
   endtask

   task automatic drive(input int k, input int j);
      if (j < 0) bus.src_vld_i[k] = 1'b0;
      else       drive_raw(k, 6'(10 + k), ent_value(k, j), 5'(k * 8 + j));
   endtask

   task automatic clear_tables();
      for (int e = 0; e < 16; e++) begin
         pres[e]    = '{-1, -1, -1};
         exp_k[e]   = -1;
         exp_j[e]   = -1;
         rdy_exp[e] = -1;
         fl[e]      = 1'b0;
      end
   endtask

   task automatic set_exp(input int e, input int k, input int j);
      exp_k[e] = k;
      exp_j[e] = j;
   endtask

   // Entered at a negedge; outputs seen at the top of step e reflect edge e-1.
   task automatic run_burst(input string name, input int n);
      for (int e = 1; e <= n; e++) begin
         if (e > 1)
            check($sformatf("%s_out%0d", name, e - 1), 128'(obs), 128'(exp_vec(exp_k[e-1], exp_j[e-1])));
         if (rdy_exp[e] >= 0)
            check($sformatf("%s_rdy%0d", name, e), 128'(bus.src_rdy_o), 128'(rdy_exp[e]));
         for (int k = 0; k < NUM_SRC; k++) drive(k, pres[e][k]);
         flush_i = fl[e];
         @(negedge clk);
      end
      check($sformatf("%s_out%0d", name, n), 128'(obs), 128'(exp_vec(exp_k[n], exp_j[n])));
      flush_i       = 1'b0;
      bus.src_vld_i = '0;
   endtask

   initial begin
      bus.src_vld_i   = '0;
      bus.src_tag_i   = '0;
      bus.src_value_i = '0;
      bus.src_rob_i   = '0;

      // Reset state
      #1;
      check("rst_out", 128'(obs), 128'(0));
      check("rst_rdy", 128'(bus.src_rdy_o), 128'(3'b111));
      @(negedge clk);
      rst = 1'b1;

      // Single ALU completion, two-cycle latency
      drive_raw(0, 6'd5, 64'hAB, 5'd3);
      @(negedge clk);
      bus.src_vld_i = '0;
      check("t1_lat1", 128'(obs), 128'(0));
      @(negedge clk);
      check("t1_out", 128'(obs), 128'({1'b1, 6'd5, 64'hAB, 1'b1, 5'd3}));
      @(negedge clk);
      check("t1_idle", 128'(obs), 128'(0));

      // Load FIFO fills and the load source holds its valid (rr starts at 1)
      clear_tables();
      pres[1] = '{4, 4, 4};
      pres[2] = '{5, 5, 5};
      pres[3] = '{-1, -1, 6};
      pres[4] = '{-1, -1, 6};
      pres[5] = '{-1, -1, 7};
      pres[6] = '{-1, -1, 7};
      pres[7] = '{-1, -1, 7};
      set_exp(2, 1, 4); set_exp(3, 2, 4); set_exp(4, 0, 4); set_exp(5, 1, 5);
      set_exp(6, 2, 5); set_exp(7, 0, 5); set_exp(8, 2, 6); set_exp(9, 2, 7);
      rdy_exp[1] = 3'b111; rdy_exp[2] = 3'b111; rdy_exp[3] = 3'b010; rdy_exp[4] = 3'b110;
      rdy_exp[5] = 3'b011; rdy_exp[6] = 3'b011; rdy_exp[7] = 3'b111;
      run_burst("t4", 10);

      // All three sources pushing, grants rotate 0,1,2 (rr starts at 0)
      clear_tables();
      pres[1] = '{0, 0, 0};
      pres[2] = '{1, 1, 1};
      pres[3] = '{2, 2, 2};
      pres[4] = '{3, 2, 2};
      pres[5] = '{3, 3, 2};
      pres[6] = '{3, 3, 3};
      set_exp(2, 0, 0); set_exp(3, 1, 0); set_exp(4, 2, 0); set_exp(5, 0, 1);
      set_exp(6, 1, 1); set_exp(7, 2, 1); set_exp(8, 0, 2); set_exp(9, 1, 2);
      set_exp(10, 2, 2); set_exp(11, 0, 3);
      rdy_exp[1] = 3'b111; rdy_exp[2] = 3'b111; rdy_exp[3] = 3'b001;
      rdy_exp[4] = 3'b010; rdy_exp[5] = 3'b100; rdy_exp[6] = 3'b001;
      run_burst("t2", 12);

      // ZERO_TAG completion: ROB done only
      drive_raw(1, 6'd0, 64'h1234, 5'd7);
      @(negedge clk);
      bus.src_vld_i = '0;
      @(negedge clk);
      check("t3_out", 128'(obs), 128'({1'b0, 6'd0, 64'd0, 1'b1, 5'd7}));

      // Flush with queued entries and a concurrent push (rr starts at 2)
      clear_tables();
      pres[1] = '{6, 6, 6};
      pres[2] = '{7, -1, -1};
      pres[3] = '{-1, 7, 7};
      fl[3]   = 1'b1;
      set_exp(2, 2, 6);
      rdy_exp[1] = 3'b111; rdy_exp[2] = 3'b111; rdy_exp[3] = 3'b110;
      rdy_exp[4] = 3'b111; rdy_exp[5] = 3'b111;
      run_burst("t5", 6);

      // Async reset between edges, mid-burst
      for (int k = 0; k < NUM_SRC; k++) drive(k, 0);
      @(negedge clk);
      for (int k = 0; k < NUM_SRC; k++) drive(k, 1);
      @(negedge clk);
      check("t6_pre", 128'(obs), 128'(exp_vec(0, 0)));
      bus.src_vld_i = '0;
      #2 rst = 1'b0;
      #1;
      check("t6_async", 128'(obs), 128'(0));
      check("t6_rdy", 128'(bus.src_rdy_o), 128'(3'b111));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_lost1", 128'(obs), 128'(0));
      @(negedge clk);
      check("t6_lost2", 128'(obs), 128'(0));
      drive(2, 5);
      @(negedge clk);
      bus.src_vld_i = '0;
      check("t6_lat1", 128'(obs), 128'(0));
      @(negedge clk);
      check("t6_out", 128'(obs), 128'(exp_vec(2, 5)));
      @(negedge clk);
      check("t6_idle", 128'(obs), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
